perf_counter_bank: RTL and testbench

Synthesizable, parametrised performance-counter bank for the rasterizer test harness and FPGA builds. It aligns per-lane sample-valid with the hit result arriving PIPE_DEPTH cycles later. It counts samples, hits, triangles, cycles and stall cycles in saturating counters, and emits a windowed snapshot through a valid/ready report port. The simulation-only monitor it replaces only displayed running totals; this block adds windowing, freeze/clear, snapshot back-pressure and drop accounting.

---
 rtl/perf_counter_bank.sv | 159 +++++++++++++++
 tb/tb_perf_counter_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Windowed performance-counter bank: aligns sample-valid with delayed hit results,
// keeps saturating event counters and hands out snapshots on a valid/ready port.
module perf_counter_bank #(
  parameter int MULTI_TEST = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 32,
  parameter int WINDOW     = 1024,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [MULTI_TEST-1:0] validSamp_R16H,
  input  logic [MULTI_TEST-1:0] hit_valid_R18H,
  input  logic                  tri_new_R16H,
  input  logic                  stall_R16H,
  input  logic                  snap_req,
  input  logic                  report_ready,
  output logic                  report_valid,
  output logic [CNT_W-1:0]      report_samples,
  output logic [CNT_W-1:0]      report_hits,
  output logic [CNT_W-1:0]      report_tris,
  output logic [CNT_W-1:0]      report_cycles,
  output logic [CNT_W-1:0]      report_stalls,
  output logic [DROP_W-1:0]     report_dropped,
  output logic                  report_sat
);

  localparam int INC_W = $clog2(MULTI_TEST + 1);
  localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int NCNT  = 5;

  logic [MULTI_TEST-1:0] vs_d [PIPE_DEPTH];
  logic                  tn_d [PIPE_DEPTH];

  // Alignment pipe runs freely; only rst touches it.
  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        vs_d[gi] <= '0;
        tn_d[gi] <= 1'b0;
      end else if (gi == 0) begin
        vs_d[gi] <= validSamp_R16H;
        tn_d[gi] <= tri_new_R16H;
      end else begin
        vs_d[gi] <= vs_d[(gi > 0) ? gi - 1 : 0];
        tn_d[gi] <= tn_d[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  logic [INC_W-1:0] samp_cnt;
  logic [INC_W-1:0] hit_cnt;
  logic [INC_W-1:0] inc [NCNT];

  always_comb begin
    samp_cnt = '0;
    hit_cnt  = '0;
    for (int i = 0; i < MULTI_TEST; i++) begin
      samp_cnt = samp_cnt + INC_W'(vs_d[PIPE_DEPTH-1][i]);
      hit_cnt  = hit_cnt + INC_W'(vs_d[PIPE_DEPTH-1][i] & hit_valid_R18H[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      inc[i] = '0;
    end
    if (en) begin
      inc[0] = samp_cnt;
      inc[1] = hit_cnt;
      inc[2] = INC_W'(tn_d[PIPE_DEPTH-1]);
      inc[3] = INC_W'(1);
      inc[4] = INC_W'(stall_R16H);
    end
  end

  logic [TMR_W-1:0]  timer_reg;
  logic              sat_reg;
  logic [DROP_W-1:0] drop_reg;
  logic              auto_snap;
  logic              snap_evt;
  logic              restart;
  logic              load;

  assign auto_snap = (WINDOW != 0) && en && (timer_reg == TMR_W'(WINDOW - 1));
  assign snap_evt  = auto_snap || snap_req;
  assign restart   = clear || snap_evt;
  assign load      = !clear && snap_evt && (!report_valid || report_ready);

  logic [CNT_W-1:0] cnt_sum [NCNT];
  logic [CNT_W-1:0] rpt_val [NCNT];
  logic [NCNT-1:0]  cnt_ovf;

  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    logic [CNT_W:0]   wide_sum;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] rpt_reg;

    // Carry out of the widened add is the saturation condition.
    assign wide_sum     = {1'b0, cnt_reg} + (CNT_W + 1)'(inc[gi]);
    assign cnt_ovf[gi]  = wide_sum[CNT_W];
    assign cnt_sum[gi]  = wide_sum[CNT_W] ? '1 : wide_sum[CNT_W-1:0];
    assign rpt_val[gi]  = rpt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
        rpt_reg <= '0;
      end else begin
        cnt_reg <= restart ? '0 : cnt_sum[gi];
        if (load) begin
          rpt_reg <= cnt_sum[gi];
        end
      end
    end
  end

  assign report_samples = rpt_val[0];
  assign report_hits    = rpt_val[1];
  assign report_tris    = rpt_val[2];
  assign report_cycles  = rpt_val[3];
  assign report_stalls  = rpt_val[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg      <= '0;
      sat_reg        <= 1'b0;
      drop_reg       <= '0;
      report_valid   <= 1'b0;
      report_dropped <= '0;
      report_sat     <= 1'b0;
    end else begin
      if (report_valid && report_ready) begin
        report_valid <= 1'b0;
      end
      if (restart) begin
        timer_reg <= '0;
        sat_reg   <= 1'b0;
      end else begin
        if (en) begin
          timer_reg <= timer_reg + TMR_W'(1);
        end
        sat_reg <= sat_reg | (|cnt_ovf);
      end
      // A rejected snapshot still restarts the window so windows stay aligned.
      if (load) begin
        report_valid   <= 1'b1;
        report_dropped <= drop_reg;
        report_sat     <= sat_reg | (|cnt_ovf);
        drop_reg       <= '0;
      end else if (!clear && snap_evt && (drop_reg != '1)) begin
        drop_reg <= drop_reg + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three parameterisations share one stimulus stream and
// are checked each cycle against an event-total model plus directed literal checks.
module tb_perf_counter_bank;

  localparam int N = 3;
  localparam int WIN [N] = '{0, 8, 0};
  localparam int CW  [N] = '{32, 32, 4};

  logic       clk;
  logic       rst, en, clear, tn, stall, snap, ready;
  logic [3:0] vs, hit;

  logic        rv    [N];
  logic        o_sat [N];
  logic [31:0] o_smp [N];
  logic [31:0] o_hit [N];
  logic [31:0] o_tri [N];
  logic [31:0] o_cyc [N];
  logic [31:0] o_stl [N];
  logic [7:0]  o_drop[N];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    logic [CW[gi]-1:0] s, h, t, c, st;
    logic [7:0]        d;
    logic              v, sa;

    perf_counter_bank #(
      .MULTI_TEST(4), .PIPE_DEPTH(3), .CNT_W(CW[gi]), .WINDOW(WIN[gi]), .DROP_W(8)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .validSamp_R16H(vs), .hit_valid_R18H(hit),
      .tri_new_R16H(tn), .stall_R16H(stall),
      .snap_req(snap), .report_ready(ready),
      .report_valid(v),
      .report_samples(s), .report_hits(h), .report_tris(t),
      .report_cycles(c), .report_stalls(st),
      .report_dropped(d), .report_sat(sa)
    );

    assign rv[gi]     = v;
    assign o_sat[gi]  = sa;
    assign o_drop[gi] = d;
    assign o_smp[gi]  = 32'(s);
    assign o_hit[gi]  = 32'(h);
    assign o_tri[gi]  = 32'(t);
    assign o_cyc[gi]  = 32'(c);
    assign o_stl[gi]  = 32'(st);
  end

  // Model: unbounded event totals per window, clamped only when reported.
  longint m_smp[N], m_hit[N], m_tri[N], m_cyc[N], m_stl[N];
  int     m_tmr[N], m_drop[N];
  bit     m_rv[N];
  longint r_smp[N], r_hit[N], r_tri[N], r_cyc[N], r_stl[N];
  int     r_drop[N];
  bit     r_sat[N];
  logic [3:0] vq[$];
  bit         tq[$];

  function automatic longint clampv(longint v, longint m);
    return (v > m) ? m : v;
  endfunction

  always @(posedge clk) begin : p_model
    logic [3:0] dv;
    bit         dt, evt;
    longint     cmax;
    if (rst) begin
      vq.delete();
      tq.delete();
      repeat (3) begin
        vq.push_back(4'd0);
        tq.push_back(1'b0);
      end
      for (int i = 0; i < N; i++) begin
        m_smp[i] = 0; m_hit[i] = 0; m_tri[i] = 0; m_cyc[i] = 0; m_stl[i] = 0;
        m_tmr[i] = 0; m_drop[i] = 0; m_rv[i] = 0;
        r_smp[i] = 0; r_hit[i] = 0; r_tri[i] = 0; r_cyc[i] = 0; r_stl[i] = 0;
        r_drop[i] = 0; r_sat[i] = 0;
      end
    end else begin
      dv = vq.pop_front();
      dt = tq.pop_front();
      vq.push_back(vs);
      tq.push_back(tn);
      for (int i = 0; i < N; i++) begin
        cmax = (longint'(1) << CW[i]) - 1;
        if (en) begin
          m_smp[i] += $countones(dv);
          m_hit[i] += $countones(dv & hit);
          m_tri[i] += longint'(dt);
          m_cyc[i] += 1;
          m_stl[i] += longint'(stall);
        end
        evt = snap || (en && WIN[i] != 0 && m_tmr[i] == WIN[i] - 1);
        if (m_rv[i] && ready) m_rv[i] = 0;
        if (!clear && evt) begin
          if (!m_rv[i]) begin
            r_smp[i] = clampv(m_smp[i], cmax);
            r_hit[i] = clampv(m_hit[i], cmax);
            r_tri[i] = clampv(m_tri[i], cmax);
            r_cyc[i] = clampv(m_cyc[i], cmax);
            r_stl[i] = clampv(m_stl[i], cmax);
            r_sat[i] = (m_smp[i] > cmax) || (m_hit[i] > cmax) || (m_tri[i] > cmax) ||
                       (m_cyc[i] > cmax) || (m_stl[i] > cmax);
            r_drop[i] = m_drop[i];
            m_drop[i] = 0;
            m_rv[i]   = 1;
          end else if (m_drop[i] < 255) begin
            m_drop[i] += 1;
          end
        end
        if (clear || evt) begin
          m_smp[i] = 0; m_hit[i] = 0; m_tri[i] = 0; m_cyc[i] = 0; m_stl[i] = 0;
          m_tmr[i] = 0;
        end else if (en) begin
          m_tmr[i] += 1;
        end
      end
    end
  end

  task automatic chk(string nm, longint got, longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin : p_compare
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid[%0d]", i), longint'(rv[i]), longint'(m_rv[i]));
      chk($sformatf("samples[%0d]", i), longint'(o_smp[i]), r_smp[i]);
      chk($sformatf("hits[%0d]", i), longint'(o_hit[i]), r_hit[i]);
      chk($sformatf("tris[%0d]", i), longint'(o_tri[i]), r_tri[i]);
      chk($sformatf("cycles[%0d]", i), longint'(o_cyc[i]), r_cyc[i]);
      chk($sformatf("stalls[%0d]", i), longint'(o_stl[i]), r_stl[i]);
      chk($sformatf("dropped[%0d]", i), longint'(o_drop[i]), longint'(r_drop[i]));
      chk($sformatf("sat[%0d]", i), longint'(o_sat[i]), longint'(r_sat[i]));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lchk(string nm, longint got, longint exp);
    $display("check %s got %0d want %0d", nm, got, exp);
    chk(nm, got, exp);
  endtask

  initial begin
    rst = 1; en = 0; clear = 0; vs = 0; hit = 0; tn = 0; stall = 0; snap = 0; ready = 1;
    step(2);
    lchk("rst_valid", longint'(rv[0]), 0);
    lchk("rst_cycles", longint'(o_cyc[1]), 0);
    rst = 0; en = 1;

    // Idle then manual snapshot.
    step(10);
    lchk("idle_valid", longint'(rv[0]), 0);
    snap = 1; step(1); snap = 0;
    lchk("idle_snap_valid", longint'(rv[0]), 1);
    lchk("idle_snap_cycles", longint'(o_cyc[0]), 11);
    lchk("idle_snap_samples", longint'(o_smp[0]), 0);

    // Hit aligned exactly PIPE_DEPTH cycles after the sample.
    vs = 4'b1011; step(1); vs = 0; step(2);
    hit = 4'b0011; step(1); hit = 0;
    snap = 1; step(1); snap = 0;
    lchk("align_samples", longint'(o_smp[0]), 3);
    lchk("align_hits", longint'(o_hit[0]), 2);

    // Hit one cycle late.
    vs = 4'b1011; step(1); vs = 0; step(3);
    hit = 4'b0011; step(1); hit = 0;
    snap = 1; step(1); snap = 0;
    lchk("misalign_samples", longint'(o_smp[0]), 3);
    lchk("misalign_hits", longint'(o_hit[0]), 0);

    // Auto window of 8 with alternating stalls.
    clear = 1; step(1); clear = 0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        stall = (k % 2 == 0);
        step(1);
      end
      lchk("win_valid", longint'(rv[1]), 1);
      lchk("win_cycles", longint'(o_cyc[1]), 8);
      lchk("win_stalls", longint'(o_stl[1]), 4);
      lchk("win_dropped", longint'(o_drop[1]), 0);
    end
    stall = 0;

    // Back-pressure: two auto snapshots lost while the first is held.
    clear = 1; step(1); clear = 0; ready = 0;
    step(30);
    lchk("bp_hold_valid", longint'(rv[1]), 1);
    lchk("bp_hold_cycles", longint'(o_cyc[1]), 8);
    lchk("bp_hold_dropped", longint'(o_drop[1]), 0);
    ready = 1; step(1);
    lchk("bp_consumed", longint'(rv[1]), 0);
    step(1);
    lchk("bp_next_valid", longint'(rv[1]), 1);
    lchk("bp_next_dropped", longint'(o_drop[1]), 2);
    lchk("bp_next_cycles", longint'(o_cyc[1]), 8);

    // Saturation of the 4-bit instance.
    clear = 1; step(1); clear = 0;
    vs = 4'hF; step(5); vs = 0; step(3);
    snap = 1; step(1); snap = 0;
    lchk("sat_samples4", longint'(o_smp[2]), 15);
    lchk("sat_flag4", longint'(o_sat[2]), 1);
    lchk("sat_cycles4", longint'(o_cyc[2]), 9);
    lchk("sat_samples32", longint'(o_smp[0]), 20);
    lchk("sat_flag32", longint'(o_sat[0]), 0);

    // Freeze mid-window.
    step(3); en = 0; step(5); en = 1; step(2);
    snap = 1; step(1); snap = 0;
    lchk("freeze_cycles", longint'(o_cyc[0]), 6);
    lchk("freeze_sat4", longint'(o_sat[2]), 0);

    // Clear beats snapshot.
    clear = 1; snap = 1; step(1); clear = 0; snap = 0;
    lchk("clrsnap_valid", longint'(rv[0]), 0);
    step(2); snap = 1; step(1); snap = 0;
    lchk("clrsnap_cycles", longint'(o_cyc[0]), 3);
    lchk("clrsnap_dropped", longint'(o_drop[0]), 0);

    // Clear+snap while blocked must not count a drop; a plain blocked snap must.
    ready = 0; clear = 1; snap = 1; step(1); clear = 0; snap = 0;
    lchk("blk_hold_valid", longint'(rv[0]), 1);
    lchk("blk_hold_cycles", longint'(o_cyc[0]), 3);
    snap = 1; step(1); snap = 0;
    ready = 1; step(1);
    lchk("blk_consumed", longint'(rv[0]), 0);
    snap = 1; step(1); snap = 0;
    lchk("blk_dropped", longint'(o_drop[0]), 1);
    lchk("blk_cycles", longint'(o_cyc[0]), 2);

    // Reset discards a pending report.
    ready = 0; snap = 1; step(1); snap = 0;
    lchk("rst_pending_valid", longint'(rv[0]), 1);
    rst = 1; step(1); rst = 0;
    lchk("rst_mid_valid", longint'(rv[0]), 0);
    lchk("rst_mid_cycles", longint'(o_cyc[0]), 0);
    lchk("rst_mid_dropped", longint'(o_drop[0]), 0);
    ready = 1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
